// File: rtl/sprite_pkg.sv
// Shared constants for the sprite overlay renderer: register map, attr bit
// positions and pattern row width.
package sprite_pkg;

   localparam int PAT_W = 8;

   localparam logic [3:0] OFF_X    = 4'd8;
   localparam logic [3:0] OFF_Y    = 4'd9;
   localparam logic [3:0] OFF_ATTR = 4'd10;
   localparam logic [3:0] OFF_COLL = 4'd11;

   localparam int ATTR_W     = 3;
   localparam int ATTR_EN    = 0;
   localparam int ATTR_HFLIP = 1;
   localparam int ATTR_VFLIP = 2;

endpackage

// File: rtl/sprite_unit.sv
// One sprite: pattern rows, shadow/active position, attr, and a two-stage
// per-beam opaque pipeline.
module sprite_unit
   import sprite_pkg::*;
#(
   parameter int SPR_H  = 8,
   parameter int HPOS_W = 8,
   parameter int VPOS_W = 7
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [3:0]        offset,
   input  logic [7:0]        wdata,
   input  logic              vsync_rise,
   input  logic [HPOS_W-1:0] hpos,
   input  logic [VPOS_W-1:0] vpos,
   output logic              opaque,
   output logic [7:0]        rd_data
);

   localparam int RW = (SPR_H > 1) ? $clog2(SPR_H) : 1;

   logic [PAT_W-1:0]  pat_q [SPR_H];
   logic [PAT_W-1:0]  pat_d [SPR_H];
   logic [HPOS_W-1:0] x_sh_q, x_sh_d, x_q, x_d;
   logic [VPOS_W-1:0] y_sh_q, y_sh_d, y_q, y_d;
   logic [ATTR_W-1:0] attr_q, attr_d;
   logic              hit_q, hit_d, pbit_q, pbit_d, opaque_q, opaque_d;

   logic [HPOS_W-1:0] col;
   logic [VPOS_W-1:0] row;
   logic [2:0]        col_sel;
   logic [RW-1:0]     row_sel;

   always_comb begin
      pat_d  = pat_q;
      x_sh_d = x_sh_q;
      y_sh_d = y_sh_q;
      attr_d = attr_q;
      if (we) begin
         if (int'(offset) < SPR_H) begin
            pat_d[offset[RW-1:0]] = wdata;
         end else begin
            case (offset)
               OFF_X:    x_sh_d = HPOS_W'(wdata);
               OFF_Y:    y_sh_d = VPOS_W'(wdata);
               OFF_ATTR: attr_d = wdata[ATTR_W-1:0];
               default:  ;
            endcase
         end
      end
      // Latch from the post-write shadow so a write on the edge cycle wins.
      x_d = x_q;
      y_d = y_q;
      if (vsync_rise) begin
         x_d = x_sh_d;
         y_d = y_sh_d;
      end
   end

   always_comb begin
      col      = hpos - x_q;
      row      = vpos - y_q;
      hit_d    = attr_q[ATTR_EN] && (col < HPOS_W'(PAT_W)) && (int'(row) < SPR_H);
      col_sel  = attr_q[ATTR_HFLIP] ? (3'd7 - col[2:0]) : col[2:0];
      row_sel  = attr_q[ATTR_VFLIP] ? (RW'(SPR_H - 1) - row[RW-1:0]) : row[RW-1:0];
      pbit_d   = hit_d ? pat_q[row_sel][col_sel] : 1'b0;
      opaque_d = hit_q & pbit_q;
   end

   always_comb begin
      rd_data = '0;
      if (int'(offset) < SPR_H) begin
         rd_data = pat_q[offset[RW-1:0]];
      end else begin
         case (offset)
            OFF_X:    rd_data = 8'(x_sh_q);
            OFF_Y:    rd_data = 8'(y_sh_q);
            OFF_ATTR: rd_data = 8'(attr_q);
            default:  rd_data = '0;
         endcase
      end
   end

   // Pattern storage carries no reset; software loads it before enabling.
   always_ff @(posedge clk) begin
      pat_q <= pat_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_sh_q   <= '0;
         y_sh_q   <= '0;
         x_q      <= '0;
         y_q      <= '0;
         attr_q   <= '0;
         hit_q    <= 1'b0;
         pbit_q   <= 1'b0;
         opaque_q <= 1'b0;
      end else begin
         x_sh_q   <= x_sh_d;
         y_sh_q   <= y_sh_d;
         x_q      <= x_d;
         y_q      <= y_d;
         attr_q   <= attr_d;
         hit_q    <= hit_d;
         pbit_q   <= pbit_d;
         opaque_q <= opaque_d;
      end
   end

   assign opaque = opaque_q;

endmodule

// File: rtl/sprite_engine.sv
// Multi-sprite overlay: CPU register decode and readback, vsync edge detect,
// lowest-index priority resolve and sprite-to-sprite collision tracking.
module sprite_engine
   import sprite_pkg::*;
#(
   parameter int NUM_SPRITES = 4,
   parameter int SPR_H       = 8,
   parameter int HPOS_W      = 8,
   parameter int VPOS_W      = 7
) (
   input  logic                                            clk,
   input  logic                                            reset,
   input  logic                                            we,
   input  logic [4+$clog2(NUM_SPRITES)-1:0]                address,
   input  logic [7:0]                                      wdata,
   output logic [7:0]                                      rdata,
   input  logic [HPOS_W-1:0]                               hpos,
   input  logic [VPOS_W-1:0]                               vpos,
   input  logic                                            vsync,
   output logic                                            pixel,
   output logic [((NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1)-1:0] pixel_idx
);

   localparam int AW = 4 + $clog2(NUM_SPRITES);
   localparam int IW = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;

   logic [AW-1:0]          spr_sel;
   logic [3:0]             offset;
   logic                   addr_ok;
   logic                   vsync_q, vsync_d, vsync_rise;
   logic [NUM_SPRITES-1:0] unit_we, opaque_vec, coll_hit;
   logic [NUM_SPRITES-1:0] coll_live_q, coll_live_d, coll_frame_q, coll_frame_d;
   logic [7:0]             unit_rd [NUM_SPRITES];
   logic [7:0]             rdata_q, rdata_d;

   assign spr_sel    = address >> 4;
   assign offset     = address[3:0];
   assign addr_ok    = int'(spr_sel) < NUM_SPRITES;
   assign vsync_d    = vsync;
   assign vsync_rise = vsync & ~vsync_q;

   for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_spr
      assign unit_we[i] = we && addr_ok && (spr_sel == AW'(i));

      sprite_unit #(
         .SPR_H  (SPR_H),
         .HPOS_W (HPOS_W),
         .VPOS_W (VPOS_W)
      ) u_spr (
         .clk        (clk),
         .rst_n      (reset),
         .we         (unit_we[i]),
         .offset     (offset),
         .wdata      (wdata),
         .vsync_rise (vsync_rise),
         .hpos       (hpos),
         .vpos       (vpos),
         .opaque     (opaque_vec[i]),
         .rd_data    (unit_rd[i])
      );
   end

   always_comb begin
      pixel     = |opaque_vec;
      pixel_idx = '0;
      for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
         if (opaque_vec[i]) pixel_idx = IW'(i);
      end
   end

   // Edge-cycle hits are folded into the frame snapshot before the clear.
   always_comb begin
      coll_hit = '0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
         coll_hit[i] = opaque_vec[i] &&
                       ((opaque_vec & ~(NUM_SPRITES'(1) << i)) != '0);
      end
      coll_live_d  = coll_live_q | coll_hit;
      coll_frame_d = coll_frame_q;
      if (vsync_rise) begin
         coll_frame_d = coll_live_d;
         coll_live_d  = '0;
      end
   end

   always_comb begin
      rdata_d = '0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
         if (addr_ok && (spr_sel == AW'(i))) begin
            rdata_d = unit_rd[i];
            if (offset == OFF_COLL) rdata_d = {7'd0, coll_frame_q[i]};
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vsync_q      <= 1'b0;
         coll_live_q  <= '0;
         coll_frame_q <= '0;
         rdata_q      <= '0;
      end else begin
         vsync_q      <= vsync_d;
         coll_live_q  <= coll_live_d;
         coll_frame_q <= coll_frame_d;
         rdata_q      <= rdata_d;
      end
   end

   assign rdata = rdata_q;

endmodule

// File: tb/tb_sprite_engine.sv
// Bench for sprite_engine: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a behavioural model.
module tb_sprite_engine;

   localparam int NS = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       we = 1'b0;
   logic [5:0] address = '0;
   logic [7:0] wdata = '0;
   logic [7:0] rdata;
   logic [7:0] hpos = '0;
   logic [6:0] vpos = '0;
   logic       vsync = 1'b0;
   logic       pixel;
   logic [1:0] pixel_idx;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   sprite_engine #(
      .NUM_SPRITES (NS),
      .SPR_H       (8),
      .HPOS_W      (8),
      .VPOS_W      (7)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .we        (we),
      .address   (address),
      .wdata     (wdata),
      .rdata     (rdata),
      .hpos      (hpos),
      .vpos      (vpos),
      .vsync     (vsync),
      .pixel     (pixel),
      .pixel_idx (pixel_idx)
   );

   task automatic check(input string name, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [7:0]    m_pat [NS][8];
   logic [7:0]    m_xs [NS];
   logic [7:0]    m_xa [NS];
   logic [6:0]    m_ys [NS];
   logic [6:0]    m_ya [NS];
   logic [2:0]    m_attr [NS];
   logic [NS-1:0] m_live, m_frame, m_out, m_pipe, t_hits, t_nxt;
   logic          m_vs, t_rise;
   logic [7:0]    m_rd;
   int            t_s, t_o;

   function automatic logic [NS-1:0] m_eval(input int h, input int v);
      logic [NS-1:0] r;
      int c, rw;
      r = '0;
      for (int s = 0; s < NS; s++) begin
         c  = (h - int'(m_xa[s]) + 256) % 256;
         rw = (v - int'(m_ya[s]) + 128) % 128;
         if (m_attr[s][0] && c < 8 && rw < 8) begin
            if (m_attr[s][1]) c = 7 - c;
            if (m_attr[s][2]) rw = 7 - rw;
            r[s] = m_pat[s][rw][c];
         end
      end
      return r;
   endfunction

   function automatic logic [7:0] m_read(input int a);
      int s, o;
      s = a / 16;
      o = a % 16;
      if (o < 8) return m_pat[s][o];
      case (o)
         8:       return m_xs[s];
         9:       return {1'b0, m_ys[s]};
         10:      return {5'b0, m_attr[s]};
         11:      return {7'b0, m_frame[s]};
         default: return 8'd0;
      endcase
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int s = 0; s < NS; s++) begin
            m_xs[s] = '0; m_xa[s] = '0; m_ys[s] = '0; m_ya[s] = '0; m_attr[s] = '0;
         end
         m_live = '0; m_frame = '0; m_out = '0; m_pipe = '0; m_vs = 1'b0; m_rd = '0;
      end else begin
         m_rd   = m_read(int'(address));
         t_rise = vsync && !m_vs;
         m_vs   = vsync;
         t_hits = ($countones(m_out) >= 2) ? m_out : '0;
         if (t_rise) begin
            m_frame = m_live | t_hits;
            m_live  = '0;
         end else begin
            m_live = m_live | t_hits;
         end
         t_nxt = m_eval(int'(hpos), int'(vpos));
         if (we) begin
            t_s = int'(address) / 16;
            t_o = int'(address) % 16;
            if (t_o < 8) m_pat[t_s][t_o] = wdata;
            else if (t_o == 8) m_xs[t_s] = wdata;
            else if (t_o == 9) m_ys[t_s] = wdata[6:0];
            else if (t_o == 10) m_attr[t_s] = wdata[2:0];
         end
         if (t_rise) begin
            for (int s = 0; s < NS; s++) begin
               m_xa[s] = m_xs[s];
               m_ya[s] = m_ys[s];
            end
         end
         m_out  = m_pipe;
         m_pipe = t_nxt;
      end
   end

   int c_idx;
   always @(negedge clk) begin
      c_idx = 0;
      for (int i = NS - 1; i >= 0; i--) if (m_out[i]) c_idx = i;
      check("model_pixel", int'(pixel), int'(m_out != '0));
      check("model_pixel_idx", int'(pixel_idx), c_idx);
      check("model_rdata", int'(rdata), int'(m_rd));
   end

   // ---------------- stimulus helpers ----------------
   task automatic wr(input int spr, input int off, input int d);
      @(negedge clk);
      we = 1'b1; address = 6'(spr * 16 + off); wdata = 8'(d);
      @(negedge clk);
      we = 1'b0;
   endtask

   task automatic rd(input int spr, input int off, input int exp, input string name);
      @(negedge clk);
      address = 6'(spr * 16 + off);
      @(negedge clk);
      check(name, int'(rdata), exp);
   endtask

   task automatic probe(input int h, input int v, input int exp_pix, input int exp_idx,
                        input string name);
      @(negedge clk);
      hpos = 8'(h); vpos = 7'(v);
      @(negedge clk);
      @(negedge clk);
      check(name, int'(pixel), exp_pix);
      check(name, int'(pixel_idx), exp_idx);
   endtask

   task automatic vs_pulse();
      @(negedge clk); vsync = 1'b1;
      @(negedge clk);
      @(negedge clk); vsync = 1'b0;
   endtask

   int h, spr, off, d;

   initial begin
      repeat (3) @(negedge clk);
      check("reset_pixel", int'(pixel), 0);
      check("reset_rdata", int'(rdata), 0);
      reset = 1'b1;
      for (int s = 0; s < NS; s++)
         for (int r = 0; r < 8; r++) wr(s, r, 0);
      rd(0, 10, 0, "reset_attr");

      // single sprite, shadow vs active position
      wr(0, 10, 1); wr(0, 0, 8'h01); wr(0, 8, 10); wr(0, 9, 5);
      probe(10, 5, 0, 0, "t1_before_vsync");
      probe(0, 0, 1, 0, "t1_old_position");
      vs_pulse();
      probe(10, 5, 1, 0, "t1_hit");
      probe(11, 5, 0, 0, "t1_right_of_hit");

      // horizontal wrap at X=254
      wr(0, 0, 8'hFF); wr(0, 8, 254);
      vs_pulse();
      for (int k = 253; k <= 262; k++) begin
         h = k % 256;
         probe(h, 5, (k >= 254 && k <= 261) ? 1 : 0, 0, "t2_wrap");
      end

      // priority and collision
      wr(0, 8, 20); wr(0, 9, 20); wr(0, 0, 1);
      wr(2, 0, 1); wr(2, 8, 20); wr(2, 9, 20); wr(2, 10, 1);
      vs_pulse();
      probe(20, 20, 1, 0, "t3_priority");
      vs_pulse();
      rd(0, 11, 1, "t3_coll_s0");
      rd(1, 11, 0, "t3_coll_s1");
      rd(2, 11, 1, "t3_coll_s2");
      rd(3, 11, 0, "t3_coll_s3");
      rd(0, 11, 1, "t3_coll_reread");
      wr(0, 10, 0);
      probe(20, 20, 1, 2, "t3_idx2_alone");

      // flips
      wr(0, 8, 0); wr(2, 10, 0); wr(0, 10, 3);
      vs_pulse();
      probe(7, 20, 1, 0, "t4_hflip_hit");
      probe(0, 20, 0, 0, "t4_hflip_miss");
      wr(0, 10, 5); wr(0, 0, 0); wr(0, 7, 1);
      probe(0, 20, 1, 0, "t4_vflip_hit");
      probe(0, 27, 0, 0, "t4_vflip_miss");

      // mid-frame shadow write, then write on the edge cycle
      wr(0, 8, 50);
      probe(0, 20, 1, 0, "t5_old_x_kept");
      probe(50, 20, 0, 0, "t5_new_x_not_yet");
      rd(0, 8, 50, "t5_shadow_read");
      @(negedge clk);
      vsync = 1'b1; we = 1'b1; address = 6'(0 * 16 + 8); wdata = 8'd60;
      @(negedge clk); we = 1'b0;
      @(negedge clk); vsync = 1'b0;
      probe(60, 20, 1, 0, "t5_edge_write_hit");
      probe(50, 20, 0, 0, "t5_edge_write_old");

      // async reset mid-line
      wr(2, 8, 60); wr(2, 9, 20); wr(2, 10, 1);
      vs_pulse();
      probe(60, 20, 1, 0, "t6_overlap");
      vs_pulse();
      rd(2, 11, 1, "t6_coll_before_reset");
      @(negedge clk);
      address = 6'(0 * 16 + 8); hpos = 8'd60; vpos = 7'd20;
      repeat (2) @(negedge clk);
      check("t6_pixel_before_reset", int'(pixel), 1);
      check("t6_rdata_before_reset", int'(rdata), 60);
      @(posedge clk); #2 reset = 1'b0;
      #1;
      check("t6_pixel_in_reset", int'(pixel), 0);
      check("t6_rdata_in_reset", int'(rdata), 0);
      @(negedge clk); reset = 1'b1;
      for (int s = 0; s < NS; s++) rd(s, 10, 0, "t6_attr_cleared");
      rd(2, 11, 0, "t6_coll_cleared");
      rd(0, 8, 0, "t6_shadow_cleared");
      rd(0, 7, 1, "t6_pattern_kept");
      probe(0, 0, 0, 0, "t6_all_disabled");

      // randomized traffic against the model
      for (int n = 0; n < 4000; n++) begin
         @(negedge clk);
         we  = ($urandom_range(0, 3) == 0);
         spr = int'($urandom_range(0, NS - 1));
         off = int'($urandom_range(0, 15));
         case (off)
            8:       d = int'($urandom_range(0, 40));
            9:       d = int'($urandom_range(0, 30));
            default: d = int'($urandom_range(0, 255));
         endcase
         address = 6'(spr * 16 + off);
         wdata   = 8'(d);
         hpos    = 8'($urandom_range(0, 50));
         vpos    = 7'($urandom_range(0, 40));
         if ($urandom_range(0, 60) == 0) vsync = ~vsync;
      end
      @(negedge clk);
      we = 1'b0;
      repeat (3) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/sprite_engine.md
# sprite_engine

Multi-sprite overlay renderer for the console video path. Holds pattern, position and attribute state for `NUM_SPRITES` independent monochrome sprites and returns one priority-resolved sprite pixel per beam position. Adds per-sprite enable and flip bits, vsync-latched position updates and sprite-to-sprite collision detection. Sits between the CPU bus and the video mixer, driven by the same `hpos`/`vpos`/`vsync` timing as the background generator.

## Interface
Parameters:
- `NUM_SPRITES`, 4: number of sprites, 1..16.
- `SPR_H`, 8: pattern rows per sprite, 1..8.
- `HPOS_W`, 8: width of `hpos` and sprite X.
- `VPOS_W`, 7: width of `vpos` and sprite Y.

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: asynchronous reset, active-low.
- `we` in 1: CPU write strobe.
- `address` in `4+$clog2(NUM_SPRITES)`: {sprite index, register offset[3:0]}.
- `wdata` in 8: write data.
- `rdata` out 8: registered read data.
- `hpos` in `HPOS_W`: beam column.
- `vpos` in `VPOS_W`: beam row.
- `vsync` in 1: frame sync, active-high.
- `pixel` out 1: resolved sprite pixel.
- `pixel_idx` out `$clog2(NUM_SPRITES)` (min 1): index of the sprite that won `pixel`.

## Operation
- Per-sprite register offsets:
  - 0..`SPR_H`-1: pattern rows, 8 bits each. Bit 0 is the leftmost pixel.
  - 8: X shadow.
  - 9: Y shadow.
  - 10: attr. Bit 0 enable, bit 1 hflip, bit 2 vflip.
  - 11: collision status, read-only.
- Writes to unused offsets, or to sprite indices ≥ `NUM_SPRITES`, are ignored. Reads of these return 0.
- Reads are non-destructive. Offset 11 returns {7'b0, `coll_frame[i]`}.
- Sprite geometry:
  - col = (hpos − X) mod 2^`HPOS_W`.
  - row = (vpos − Y) mod 2^`VPOS_W`.
  - Sprite is hit when enable=1, col<8 and row<`SPR_H`.
  - Positions wrap: X=254 draws at hpos 254, 255, 0..5.
- Flips:
  - hflip selects bit 7−col.
  - vflip selects row `SPR_H`−1−row.
- Opaque = hit AND selected pattern bit.
- Priority: the lowest opaque index wins. `pixel`=1 and `pixel_idx`=winner. If no sprite is opaque, `pixel`=0 and `pixel_idx`=0.
- Position latch: the active X/Y load from the shadow registers on the vsync rising edge (detected against the registered previous vsync). If a shadow write lands in the same cycle as the edge, the active register takes the new write data. Pattern and attr writes take effect immediately.
- Collision:
  - `coll_live[i]` is set whenever sprite i is opaque while at least one other sprite is opaque at the same pixel.
  - On the vsync rising edge, `coll_frame` ← `coll_live` (including that cycle's hits) and `coll_live` clears.
- Reset (`reset`=0, asynchronous):
  - `pixel`, `pixel_idx`, `rdata` = 0.
  - Shadow and active X/Y = 0; attr = 0 (all sprites disabled).
  - `coll_live`, `coll_frame` = 0; vsync history = 0.
  - Pattern RAM is not reset.
  - Deasserting reset mid-frame produces no spurious vsync edge.

## Timing
- Pixel latency is 2 cycles:
  - Stage 1 registers `hpos`/`vpos` and per-sprite hit/row-select.
  - Stage 2 registers the opaque vector, priority result and collision update.
  - `pixel` at cycle t+2 reflects `hpos`/`vpos` at cycle t.
- Register writes are visible to the pixel pipeline from the next cycle, entering at stage 1.
- `rdata` is valid 1 cycle after `address` is presented. A read and a write to the same address in the same cycle return the old value.
- One vsync edge yields exactly one latch, regardless of how long `vsync` stays high.

## Structure
- Shared package `sprite_pkg`:
  - offset constants `OFF_X`=8, `OFF_Y`=9, `OFF_ATTR`=10, `OFF_COLL`=11;
  - attr bit positions;
  - the pattern row width constant, 8.
- Sub-module `sprite_unit`, instantiated `NUM_SPRITES` times:
  - holds one sprite's pattern rows, shadow/active X/Y and attr;
  - outputs a registered opaque bit and readback data.
- The top level contains the address decode, read mux, priority encoder, collision logic and vsync edge detect.

## Test plan
- Reset, enable sprite 0, row0=0x01, shadow X=10, Y=5, then pulse vsync → `pixel`=1 two cycles after hpos=10, vpos=5; `pixel`=0 at hpos=11.
- Sprite 0 X=254, row0=0xFF, vsync → `pixel`=1 for hpos 254, 255, 0..5; `pixel`=0 at hpos 6.
- Sprites 0 and 2 both opaque at (20,20) → `pixel_idx`=0. After the next vsync edge, offset 11 reads 1 for sprites 0 and 2 and 0 for sprite 1.
- hflip=1 with row0=0x01 at X=0 → opaque only at hpos=7. vflip=1 with `SPR_H`=8 and only row 7 set → opaque at row 0.
- Write X=50 mid-frame → the sprite stays at the old X until the vsync rising edge. A write coinciding with the edge applies in that frame.
- Assert `reset` asynchronously mid-line → `pixel`, `rdata` and collision registers go to 0 immediately and all sprites read back disabled.
